fetch_sequencer: RTL and testbench

Instruction fetch and program-sequencing block that sits in front of Control_Unit. It holds the program counter and fetches 16-bit instruction words from program memory over a request/acknowledge handshake. It presents the 6-bit opcode to Control_Unit and consumes Control_Unit's `bra` and `hlt` decisions to select the next PC. JMP/RET sequencing runs through a small internal return-address stack.

---
 rtl/fetch_sequencer.sv | 161 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Holds the program counter, fetches 16-bit instruction words over a
// req/ack handshake and hands the opcode/operand to Control_Unit. The next
// PC comes from Control_Unit's bra/hlt decisions, or from the local
// JMP/RET handling that runs through a small return-address stack.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   mem_addr   program memory address (always equals pc)
//   mem_req    fetch request, high for the whole FETCH state
//   mem_ack    memory acknowledge, mem_rdata valid in the same cycle
//   mem_rdata  instruction word: [15:10] opcode, [9:0] operand
//   opcode     current opcode to Control_Unit
//   operand    current operand (immediate / branch target)
//   ir_valid   opcode/operand hold a decoded instruction (DECODE, EXEC)
//   bra        branch taken, sampled in the final EXEC cycle
//   hlt        halt, sampled in the final EXEC cycle
//   ex_busy    multi-cycle execute stall
//   pc         address of the current instruction
//   halted     sequencer stopped until reset
//   stack_err  sticky return-stack overflow/underflow
//
// state      | meaning
// RESET_IDLE | settling after reset release, no request outstanding
// FETCH      | mem_req high on mem_addr=pc, waiting for mem_ack
// DECODE     | IR presented to Control_Unit for one cycle
// EXEC       | held while ex_busy, then next-PC select
// HALT       | stopped, exit only through reset
module fetch_sequencer #(
  parameter int ADDR_W   = 10,
  parameter int RS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [5:0]        opcode,
  output logic [9:0]        operand,
  output logic              ir_valid,
  input  logic              bra,
  input  logic              hlt,
  input  logic              ex_busy,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              stack_err
);

  localparam logic [5:0] OP_JMP = 6'h30;
  localparam logic [5:0] OP_RET = 6'h31;
  localparam int         PW     = $clog2(RS_DEPTH);

  typedef enum logic [2:0] {
    RESET_IDLE,
    FETCH,
    DECODE,
    EXEC,
    HALT
  } state_t;

  state_t            state, state_next;
  logic              idle_done;
  logic [15:0]       ir;
  logic [ADDR_W-1:0] pc_next, pc_inc, target;
  logic [ADDR_W-1:0] rs [RS_DEPTH];
  logic [PW:0]       rs_cnt;
  logic [PW-1:0]     rs_top_idx;
  logic              rs_full, rs_empty;
  logic              push, pop, err_set, ir_load;

  assign opcode     = ir[15:10];
  assign operand    = ir[9:0];
  assign ir_valid   = (state == DECODE) || (state == EXEC);
  assign halted     = (state == HALT);
  assign mem_addr   = pc;
  assign pc_inc     = pc + 1'b1;
  assign target     = ADDR_W'(ir[9:0]);
  assign rs_full    = (rs_cnt == (PW+1)'(RS_DEPTH));
  assign rs_empty   = (rs_cnt == '0);
  // Wraps to the last slot when the stack is full (count low bits are 0).
  assign rs_top_idx = rs_cnt[PW-1:0] - 1'b1;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    push       = 1'b0;
    pop        = 1'b0;
    err_set    = 1'b0;
    ir_load    = 1'b0;
    case (state)
      RESET_IDLE: begin
        if (idle_done) state_next = FETCH;
      end
      FETCH: begin
        if (mem_ack) begin
          ir_load    = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: state_next = EXEC;
      EXEC: begin
        if (!ex_busy) begin
          state_next = FETCH;
          if (hlt) begin
            state_next = HALT;
          end else if (opcode == OP_JMP) begin
            // A full stack drops the return address but the jump still goes.
            pc_next = target;
            if (rs_full) err_set = 1'b1;
            else         push    = 1'b1;
          end else if (opcode == OP_RET) begin
            if (rs_empty) begin
              err_set = 1'b1;
              pc_next = pc_inc;
            end else begin
              pop     = 1'b1;
              pc_next = rs[rs_top_idx];
            end
          end else if (bra) begin
            pc_next = target;
          end else begin
            pc_next = pc_inc;
          end
        end
      end
      HALT:    state_next = HALT;
      default: state_next = RESET_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RESET_IDLE;
      idle_done <= 1'b0;
      ir        <= '0;
      pc        <= '0;
      rs_cnt    <= '0;
      mem_req   <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      state     <= state_next;
      idle_done <= (state == RESET_IDLE);
      // Registered from next state so the request rises on FETCH entry
      // and drops the cycle after the ack.
      mem_req   <= (state_next == FETCH);
      pc        <= pc_next;
      if (ir_load) ir <= mem_rdata;
      if (push)      rs_cnt <= rs_cnt + 1'b1;
      else if (pop)  rs_cnt <= rs_cnt - 1'b1;
      if (err_set) stack_err <= 1'b1;
    end
  end

  // Stack storage carries no reset; the count alone defines emptiness.
  always_ff @(posedge clk) begin
    if (push) rs[rs_cnt[PW-1:0]] <= pc_inc;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_BRZ   = 6'h0A;
  localparam logic [5:0] OP_MULXY = 6'h12;
  localparam logic [5:0] OP_HLT   = 6'h3F;
  localparam logic [5:0] OP_JMP   = 6'h30;
  localparam logic [5:0] OP_RET   = 6'h31;
  localparam int         DEPTH    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  mem_addr;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic [5:0]  opcode;
  logic [9:0]  operand;
  logic        ir_valid;
  logic        bra = 1'b0;
  logic        hlt = 1'b0;
  logic        ex_busy = 1'b0;
  logic [9:0]  pc;
  logic        halted;
  logic        stack_err;

  fetch_sequencer #(.ADDR_W(10), .RS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .opcode(opcode),
    .operand(operand), .ir_valid(ir_valid), .bra(bra), .hlt(hlt),
    .ex_busy(ex_busy), .pc(pc), .halted(halted), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [15:0] prog [1024];

  // Architectural reference: program counter, LIFO of return addresses,
  // sticky error flag.
  int mpc;
  int mstack[$];
  bit merr;

  function automatic void model_reset();
    mpc = 0;
    mstack.delete();
    merr = 1'b0;
  endfunction

  function automatic void model_exec(input logic [15:0] w, input bit b, input bit h);
    if (h) return;
    if (w[15:10] == OP_JMP) begin
      if (mstack.size() >= DEPTH) merr = 1'b1;
      else mstack.push_back((mpc + 1) % 1024);
      mpc = int'(w[9:0]);
    end else if (w[15:10] == OP_RET) begin
      if (mstack.size() == 0) begin
        merr = 1'b1;
        mpc = (mpc + 1) % 1024;
      end else begin
        mpc = mstack.pop_back();
      end
    end else if (b) begin
      mpc = int'(w[9:0]);
    end else begin
      mpc = (mpc + 1) % 1024;
    end
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) prog[i] = 16'h0000;
  endtask

  // Leaves the DUT one time unit after the edge that entered FETCH.
  task automatic reset_dut();
    rst = 1'b0; mem_ack = 1'b0; bra = 1'b0; hlt = 1'b0; ex_busy = 1'b0;
    mem_rdata = 16'h0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_reset();
  endtask

  // Drives one instruction from FETCH to the next FETCH/HALT: waits memory
  // wait cycles, busy execute-stall cycles, then b/h in the final EXEC
  // cycle. bra/hlt carry random junk in every cycle where they must be
  // ignored. stable reports handshake hold, IR not captured early, and
  // opcode/ir_valid/pc held across EXEC.
  task automatic run_instr(input int waits, input int busy, input bit b, input bit h,
                           output logic [9:0] exp_addr, output logic [9:0] f_addr,
                           output int cycles, output logic [5:0] op_seen,
                           output bit stable);
    logic [5:0] op_prev;
    logic [9:0] pc_now;
    exp_addr = 10'(mpc);
    f_addr = mem_addr;
    cycles = 0;
    stable = (mem_req === 1'b1);
    op_prev = opcode;
    pc_now = pc;
    for (int w = 0; w < waits; w++) begin
      mem_ack = 1'b0;
      mem_rdata = ~prog[f_addr];
      @(posedge clk); #1; cycles++;
      if (mem_req !== 1'b1 || mem_addr !== f_addr || opcode !== op_prev || ir_valid !== 1'b0)
        stable = 1'b0;
    end
    mem_ack = 1'b1;
    mem_rdata = prog[f_addr];
    @(posedge clk); #1; cycles++;
    mem_ack = 1'b0;
    mem_rdata = 16'($urandom);
    op_seen = opcode;
    if (ir_valid !== 1'b1 || mem_req !== 1'b0 || operand !== prog[f_addr][9:0]) stable = 1'b0;
    ex_busy = (busy > 0);
    bra = 1'($urandom_range(1, 0));
    hlt = 1'($urandom_range(1, 0));
    @(posedge clk); #1; cycles++;
    for (int i = 0; i < busy; i++) begin
      if (opcode !== op_seen || ir_valid !== 1'b1 || pc !== pc_now) stable = 1'b0;
      bra = 1'($urandom_range(1, 0));
      hlt = 1'($urandom_range(1, 0));
      @(posedge clk); #1; cycles++;
    end
    if (opcode !== op_seen || ir_valid !== 1'b1 || pc !== pc_now) stable = 1'b0;
    ex_busy = 1'b0; bra = b; hlt = h;
    @(posedge clk); #1; cycles++;
    bra = 1'b0; hlt = 1'b0;
    model_exec(prog[exp_addr], b, h);
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    #10;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %0h expected 0", mem_req); end
    checks++; if (mem_addr !== 10'h000) begin failures++; $display("FAIL reset_mem_addr: got %0h expected 0", mem_addr); end
    checks++; if (pc !== 10'h000) begin failures++; $display("FAIL reset_pc: got %0h expected 0", pc); end
    checks++; if (opcode !== 6'h00 || operand !== 10'h000) begin failures++; $display("FAIL reset_ir: got %0h/%0h expected 0/0", opcode, operand); end
    checks++; if (ir_valid !== 1'b0 || halted !== 1'b0 || stack_err !== 1'b0) begin failures++; $display("FAIL reset_flags: got %b%b%b expected 000", ir_valid, halted, stack_err); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL idle_no_req: got %0h expected 0", mem_req); end
    mem_ack = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 10'h000) begin failures++; $display("FAIL first_fetch: got req=%0h addr=%0h expected 1/0", mem_req, mem_addr); end
    checks++; if (opcode !== 6'h00 || ir_valid !== 1'b0) begin failures++; $display("FAIL idle_ack_ignored: got op=%0h v=%0h expected 0/0", opcode, ir_valid); end
  endtask

  task automatic test_sequential();
    logic [9:0] ea, fa; int cyc; logic [5:0] op; bit st;
    clear_prog(); reset_dut();
    for (int i = 0; i < 4; i++) begin
      run_instr(0, 0, 1'b0, 1'b0, ea, fa, cyc, op, st);
      checks++; if (fa !== ea) begin failures++; $display("FAIL seq_addr: got %0h expected %0h", fa, ea); end
      checks++; if (cyc !== 3) begin failures++; $display("FAIL seq_period: got %0d expected 3", cyc); end
    end
    checks++; if (pc !== 10'h004 || mem_addr !== 10'(mpc)) begin failures++; $display("FAIL seq_pc: got %0h expected %0h", pc, mpc); end
  endtask

  task automatic test_wait();
    logic [9:0] ea, fa; int cyc; logic [5:0] op; bit st;
    clear_prog(); prog[5] = {OP_MULXY, 10'h155}; reset_dut();
    for (int i = 0; i < 5; i++) run_instr(0, 0, 1'b0, 1'b0, ea, fa, cyc, op, st);
    run_instr(2, 0, 1'b0, 1'b0, ea, fa, cyc, op, st);
    checks++; if (fa !== 10'h005) begin failures++; $display("FAIL wait_addr: got %0h expected 5", fa); end
    checks++; if (cyc !== 5) begin failures++; $display("FAIL wait_period: got %0d expected 5", cyc); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL wait_hold: got %0b expected 1", st); end
    checks++; if (op !== OP_MULXY) begin failures++; $display("FAIL wait_ir: got %0h expected %0h", op, OP_MULXY); end
  endtask

  task automatic test_branch();
    logic [9:0] ea, fa; int cyc; logic [5:0] op; bit st;
    clear_prog(); prog[0] = {OP_BRZ, 10'h040}; prog[10'h040] = {OP_BRZ, 10'h080}; reset_dut();
    run_instr(0, 0, 1'b1, 1'b0, ea, fa, cyc, op, st);
    checks++; if (mem_addr !== 10'h040) begin failures++; $display("FAIL brz_taken: got %0h expected 40", mem_addr); end
    run_instr(0, 0, 1'b0, 1'b0, ea, fa, cyc, op, st);
    checks++; if (mem_addr !== 10'h041) begin failures++; $display("FAIL brz_not_taken: got %0h expected 41", mem_addr); end
  endtask

  task automatic test_jmp_ret();
    logic [9:0] ea, fa; int cyc; logic [5:0] op; bit st;
    clear_prog();
    prog[0] = {OP_BRZ, 10'h010}; prog[10'h010] = {OP_JMP, 10'h100}; prog[10'h100] = {OP_RET, 10'h2AA};
    reset_dut();
    run_instr(0, 0, 1'b1, 1'b0, ea, fa, cyc, op, st);
    run_instr(0, 0, 1'b1, 1'b0, ea, fa, cyc, op, st);
    checks++; if (mem_addr !== 10'h100) begin failures++; $display("FAIL jmp_target: got %0h expected 100", mem_addr); end
    run_instr(0, 0, 1'b1, 1'b0, ea, fa, cyc, op, st);
    checks++; if (mem_addr !== 10'h011) begin failures++; $display("FAIL ret_addr: got %0h expected 11", mem_addr); end
    checks++; if (stack_err !== 1'b0) begin failures++; $display("FAIL ret_no_err: got %0b expected 0", stack_err); end
  endtask

  task automatic test_overflow();
    logic [9:0] ea, fa; int cyc; logic [5:0] op; bit st;
    clear_prog(); prog[0] = {OP_BRZ, 10'h200};
    for (int k = 0; k < 9; k++) prog[10'h200 + k] = {OP_JMP, 10'(10'h201 + k)};
    prog[10'h209] = {OP_RET, 10'h000};
    reset_dut();
    run_instr(0, 0, 1'b1, 1'b0, ea, fa, cyc, op, st);
    for (int k = 0; k < 9; k++) begin
      run_instr(0, 0, 1'b0, 1'b0, ea, fa, cyc, op, st);
      if (k == 7) begin
        checks++; if (stack_err !== 1'b0) begin failures++; $display("FAIL ovf_eight_ok: got %0b expected 0", stack_err); end
      end
    end
    checks++; if (stack_err !== 1'b1) begin failures++; $display("FAIL ovf_err: got %0b expected 1", stack_err); end
    checks++; if (mem_addr !== 10'h209) begin failures++; $display("FAIL ovf_jump_taken: got %0h expected 209", mem_addr); end
    run_instr(0, 0, 1'b0, 1'b0, ea, fa, cyc, op, st);
    checks++; if (mem_addr !== 10'h208 || mem_addr !== 10'(mpc)) begin failures++; $display("FAIL ovf_ret: got %0h expected 208", mem_addr); end
  endtask

  task automatic test_underflow();
    logic [9:0] ea, fa; int cyc; logic [5:0] op; bit st;
    clear_prog(); prog[0] = {OP_RET, 10'h123}; reset_dut();
    run_instr(0, 0, 1'b1, 1'b0, ea, fa, cyc, op, st);
    checks++; if (stack_err !== 1'b1) begin failures++; $display("FAIL unf_err: got %0b expected 1", stack_err); end
    checks++; if (mem_addr !== 10'h001) begin failures++; $display("FAIL unf_pc: got %0h expected 1", mem_addr); end
    run_instr(0, 0, 1'b0, 1'b0, ea, fa, cyc, op, st);
    checks++; if (stack_err !== 1'b1) begin failures++; $display("FAIL unf_sticky: got %0b expected 1", stack_err); end
  endtask

  task automatic test_wrap();
    logic [9:0] ea, fa; int cyc; logic [5:0] op; bit st;
    clear_prog(); prog[0] = {OP_BRZ, 10'h3FF}; prog[10'h3FF] = {OP_NOP, 10'h000}; reset_dut();
    run_instr(0, 0, 1'b1, 1'b0, ea, fa, cyc, op, st);
    run_instr(0, 0, 1'b0, 1'b0, ea, fa, cyc, op, st);
    checks++; if (mem_addr !== 10'h000) begin failures++; $display("FAIL pc_wrap: got %0h expected 0", mem_addr); end
    prog[10'h3FF] = {OP_JMP, 10'h050}; prog[10'h050] = {OP_RET, 10'h000};
    run_instr(0, 0, 1'b1, 1'b0, ea, fa, cyc, op, st);
    run_instr(0, 0, 1'b0, 1'b0, ea, fa, cyc, op, st);
    run_instr(0, 0, 1'b0, 1'b0, ea, fa, cyc, op, st);
    checks++; if (mem_addr !== 10'h000) begin failures++; $display("FAIL push_wrap: got %0h expected 0", mem_addr); end
  endtask

  task automatic test_busy();
    logic [9:0] ea, fa; int cyc; logic [5:0] op; bit st;
    clear_prog(); prog[0] = {OP_MULXY, 10'h00F}; reset_dut();
    run_instr(0, 4, 1'b0, 1'b0, ea, fa, cyc, op, st);
    checks++; if (cyc !== 7) begin failures++; $display("FAIL busy_period: got %0d expected 7", cyc); end
    checks++; if (st !== 1'b1 || op !== OP_MULXY) begin failures++; $display("FAIL busy_hold: got st=%0b op=%0h expected 1/%0h", st, op, OP_MULXY); end
    checks++; if (mem_addr !== 10'h001) begin failures++; $display("FAIL busy_next: got %0h expected 1", mem_addr); end
  endtask

  task automatic test_halt();
    logic [9:0] ea, fa; int cyc; logic [5:0] op; bit st; int viol;
    clear_prog(); prog[1] = {OP_HLT, 10'h000}; reset_dut();
    run_instr(0, 0, 1'b0, 1'b0, ea, fa, cyc, op, st);
    run_instr(0, 0, 1'b1, 1'b1, ea, fa, cyc, op, st);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_rise: got %0b expected 1", halted); end
    checks++; if (pc !== 10'h001) begin failures++; $display("FAIL halt_pc: got %0h expected 1", pc); end
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      mem_ack = 1'($urandom_range(1, 0)); mem_rdata = 16'($urandom);
      @(posedge clk); #1;
      if (mem_req !== 1'b0 || ir_valid !== 1'b0 || halted !== 1'b1) viol++;
    end
    mem_ack = 1'b0;
    checks++; if (viol !== 0) begin failures++; $display("FAIL halt_stays: got %0d bad cycles expected 0", viol); end
  endtask

  task automatic test_async_reset();
    logic [9:0] ea, fa; int cyc; logic [5:0] op; bit st;
    clear_prog(); prog[0] = {OP_RET, 10'h000}; prog[2] = {OP_MULXY, 10'h3C3}; reset_dut();
    for (int i = 0; i < 3; i++) run_instr(0, 0, 1'b0, 1'b0, ea, fa, cyc, op, st);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 10'h003 || stack_err !== 1'b1) begin failures++; $display("FAIL pre_reset: got req=%0h addr=%0h err=%0h expected 1/3/1", mem_req, mem_addr, stack_err); end
    #3 rst = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 10'h000 || pc !== 10'h000) begin failures++; $display("FAIL async_req: got req=%0h addr=%0h pc=%0h expected 0/0/0", mem_req, mem_addr, pc); end
    checks++; if (opcode !== 6'h00 || operand !== 10'h000 || ir_valid !== 1'b0 || stack_err !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL async_outs: got op=%0h opd=%0h v=%0b err=%0b h=%0b expected all 0", opcode, operand, ir_valid, stack_err, halted); end
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 10'h000 || opcode !== 6'h00) begin failures++; $display("FAIL restart: got req=%0h addr=%0h op=%0h expected 1/0/0", mem_req, mem_addr, opcode); end
  endtask

  task automatic test_random();
    logic [9:0] ea, fa; int cyc; logic [5:0] op; bit st; int w, bu; bit b; int r;
    for (int i = 0; i < 1024; i++) begin
      r = $urandom_range(9, 0);
      if (r < 2)      prog[i] = {OP_JMP, 10'($urandom)};
      else if (r < 4) prog[i] = {OP_RET, 10'($urandom)};
      else            prog[i] = {6'($urandom_range(47, 0)), 10'($urandom)};
    end
    reset_dut();
    for (int n = 0; n < 80; n++) begin
      w = $urandom_range(2, 0); bu = $urandom_range(2, 0); b = 1'($urandom_range(1, 0));
      run_instr(w, bu, b, 1'b0, ea, fa, cyc, op, st);
      checks++; if (fa !== ea) begin failures++; $display("FAIL rnd_addr[%0d]: got %0h expected %0h", n, fa, ea); end
      checks++; if (cyc !== 3 + w + bu) begin failures++; $display("FAIL rnd_period[%0d]: got %0d expected %0d", n, cyc, 3 + w + bu); end
      checks++; if (op !== prog[ea][15:10] || st !== 1'b1) begin failures++; $display("FAIL rnd_decode[%0d]: got op=%0h st=%0b expected %0h/1", n, op, st, prog[ea][15:10]); end
      checks++; if (stack_err !== merr) begin failures++; $display("FAIL rnd_stack_err[%0d]: got %0b expected %0b", n, stack_err, merr); end
    end
    checks++; if (mem_addr !== 10'(mpc)) begin failures++; $display("FAIL rnd_final_pc: got %0h expected %0h", mem_addr, mpc); end
  endtask

  initial begin
    clear_prog();
    model_reset();
    test_reset();
    test_sequential();
    test_wait();
    test_branch();
    test_jmp_ret();
    test_overflow();
    test_underflow();
    test_wrap();
    test_busy();
    test_halt();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
